// File: rtl/ssd_pkg.sv
// Shared types and helpers for the seven-segment display arbiter: FSM states,
// frame width, the all-segments-off frame and small index utilities.
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2,
        FORCE = 2'd3
    } ssd_state_e;

    localparam int FRAME_W = 32;

    // Segments are active-low, so all ones turns every segment and point off.
    localparam logic [FRAME_W-1:0] SSD_BLANK_FRAME = 32'hFFFF_FFFF;

    function automatic logic [7:0] ssd_onehot(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

    function automatic logic [2:0] ssd_next_idx(input logic [2:0] idx, input int n);
        return (int'(idx) + 1 >= n) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/ssd_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
import ssd_pkg::*;

module ssd_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0]   cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // cand[gi] is the source examined gi places after the pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum       = {1'b0, ptr} + (IDX_W+1)'(gi);
        assign cand[gi]  = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                         : IDX_W'(sum);
        assign hit[gi]   = req[cand[gi]];
    end

    always_comb begin
        valid = |hit;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) idx = cand[k];
        end
    end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Time-shares the 4-digit seven-segment display among NUM_REQ frame sources with
// round-robin grant, minimum dwell, a blank gap between sources and a debug force path.
import ssd_pkg::*;

module ssd_display_arbiter #(
    parameter int                 NUM_REQ      = 4,
    parameter int                 DWELL_CYCLES = 100_000_000,
    parameter int                 BLANK_CYCLES = 1_000_000,
    parameter logic [FRAME_W-1:0] BLANK_FRAME  = SSD_BLANK_FRAME,
    localparam int                IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*FRAME_W-1:0] frame_flat,
    input  logic                       force_en,
    input  logic [IDX_W-1:0]           force_sel,
    output logic [FRAME_W-1:0]         value,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [IDX_W-1:0]           active_idx,
    output logic                       blanking
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    ssd_state_e         state_reg, state_next;
    logic [FRAME_W-1:0] value_reg, value_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               blanking_reg, blanking_next;
    logic [DW-1:0]      dwell_reg, dwell_next;
    logic [BW-1:0]      blank_reg, blank_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;

    logic [FRAME_W-1:0] frame [NUM_REQ];
    logic [NUM_REQ-1:0] pick_oh, force_oh, act_oh;
    logic               pick_valid, force_ok, others;
    logic [IDX_W-1:0]   pick_idx;
    logic               go_show, go_blank, go_idle;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
        assign frame[gi]    = frame_flat[FRAME_W*gi +: FRAME_W];
        assign pick_oh[gi]  = (pick_idx  == IDX_W'(gi));
        assign force_oh[gi] = (force_sel == IDX_W'(gi));
        assign act_oh[gi]   = (idx_reg   == IDX_W'(gi));
    end

    ssd_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign force_ok = (int'(force_sel) < NUM_REQ);
    assign others   = |(req & ~act_oh);

    always_comb begin
        state_next    = state_reg;
        value_next    = value_reg;
        gnt_next      = gnt_reg;
        idx_next      = idx_reg;
        blanking_next = blanking_reg;
        dwell_next    = dwell_reg;
        blank_next    = blank_reg;
        ptr_next      = ptr_reg;
        go_show       = 1'b0;
        go_blank      = 1'b0;
        go_idle       = 1'b0;

        if (force_en) begin
            state_next    = FORCE;
            blanking_next = 1'b0;
            dwell_next    = '0;
            blank_next    = '0;
            value_next    = force_ok ? frame[force_sel] : BLANK_FRAME;
            gnt_next      = force_ok ? force_oh : '0;
            if (force_ok) idx_next = force_sel;
        end else begin
            unique case (state_reg)
                IDLE:  go_show = pick_valid;
                SHOW: begin
                    if (!req[idx_reg] || (dwell_reg == DWELL_LAST && others)) begin
                        go_blank = others;
                        go_idle  = !others;
                    end else begin
                        // A lone requester simply restarts its dwell window.
                        dwell_next = (dwell_reg == DWELL_LAST) ? '0 : dwell_reg + 1'b1;
                        value_next = frame[idx_reg];
                    end
                end
                BLANK: begin
                    if (blank_reg == BLANK_LAST) begin
                        go_show = pick_valid;
                        go_idle = !pick_valid;
                    end else begin
                        blank_next = blank_reg + 1'b1;
                    end
                end
                FORCE: go_blank = 1'b1;
                default: go_idle = 1'b1;
            endcase
        end

        if (go_show) begin
            state_next    = SHOW;
            value_next    = frame[pick_idx];
            gnt_next      = pick_oh;
            idx_next      = pick_idx;
            blanking_next = 1'b0;
            dwell_next    = '0;
            blank_next    = '0;
            ptr_next      = IDX_W'(ssd_next_idx(3'(pick_idx), NUM_REQ));
        end
        if (go_blank || go_idle) begin
            state_next    = go_blank ? BLANK : IDLE;
            value_next    = BLANK_FRAME;
            gnt_next      = '0;
            blanking_next = go_blank;
            dwell_next    = '0;
            blank_next    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            value_reg    <= BLANK_FRAME;
            gnt_reg      <= '0;
            idx_reg      <= '0;
            blanking_reg <= 1'b0;
            dwell_reg    <= '0;
            blank_reg    <= '0;
            ptr_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            value_reg    <= value_next;
            gnt_reg      <= gnt_next;
            idx_reg      <= idx_next;
            blanking_reg <= blanking_next;
            dwell_reg    <= dwell_next;
            blank_reg    <= blank_next;
            ptr_reg      <= ptr_next;
        end
    end

    assign value      = value_reg;
    assign gnt        = gnt_reg;
    assign active_idx = idx_reg;
    assign blanking   = blanking_reg;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Bench for ssd_display_arbiter: scripted scenarios with literal expectations plus
// a randomized run checked every cycle against a behavioural display-sharing model.
module tb_ssd_display_arbiter;

    localparam int N     = 4;
    localparam int DWELL = 8;
    localparam int GAP   = 2;
    localparam logic [31:0] BLANKF = 32'hFFFF_FFFF;

    localparam int M_IDLE = 0, M_SHOW = 1, M_BLANK = 2, M_FORCE = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*32-1:0] frame_flat;
    logic           force_en = 1'b0;
    logic [1:0]     force_sel = '0;
    logic [31:0]    value;
    logic [N-1:0]   gnt;
    logic [1:0]     active_idx;
    logic           blanking;

    logic [31:0] frames [N];
    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    for (genvar gi = 0; gi < N; gi++) begin : g_frame
        assign frame_flat[32*gi +: 32] = frames[gi];
    end

    always #5 clk = ~clk;

    ssd_display_arbiter #(
        .NUM_REQ(N), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(GAP), .BLANK_FRAME(BLANKF)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .frame_flat(frame_flat),
        .force_en(force_en), .force_sel(force_sel),
        .value(value), .gnt(gnt), .active_idx(active_idx), .blanking(blanking)
    );

    // Behavioural model: which source is on screen, how long it has been there, whose turn is next.
    int          m_mode = M_IDLE;
    int          m_time = 0;
    int          m_next = 0;
    int          e_src  = 0;
    logic [31:0] e_val  = BLANKF;
    logic [N-1:0] e_gnt = '0;
    logic        e_blk  = 1'b0;

    function automatic int next_turn(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++)
            if (r[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    task automatic m_dark(input int mode);
        m_mode = mode; m_time = 0; e_val = BLANKF; e_gnt = '0; e_blk = (mode == M_BLANK);
    endtask

    task automatic m_serve_or_idle();
        int w;
        w = next_turn(req, m_next);
        if (w < 0) m_dark(M_IDLE);
        else begin
            m_mode = M_SHOW; m_time = 0; e_src = w; e_val = frames[w];
            e_gnt = N'(1) << w; e_blk = 1'b0; m_next = (w + 1) % N;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_dark(M_IDLE); e_src = 0; m_next = 0;
        end else if (force_en) begin
            m_mode = M_FORCE; m_time = 0; e_blk = 1'b0;
            e_src = int'(force_sel); e_val = frames[force_sel]; e_gnt = N'(1) << force_sel;
        end else begin
            case (m_mode)
                M_IDLE: if (req != 0) m_serve_or_idle();
                M_SHOW: begin
                    logic rivals;
                    rivals = (req & ~(N'(1) << e_src)) != 0;
                    if (!req[e_src] || (m_time + 1 >= DWELL && rivals))
                        m_dark(rivals ? M_BLANK : M_IDLE);
                    else begin
                        m_time = (m_time + 1 >= DWELL) ? 0 : m_time + 1;
                        e_val  = frames[e_src];
                    end
                end
                M_BLANK: if (m_time + 1 >= GAP) m_serve_or_idle(); else m_time++;
                default: m_dark(M_BLANK);
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (value !== e_val || gnt !== e_gnt || blanking !== e_blk ||
                (e_gnt != 0 && active_idx !== 2'(e_src))) begin
                errors++;
                $display("FAIL model t=%0t: value=%h gnt=%b idx=%0d blank=%b, required value=%h gnt=%b idx=%0d blank=%b",
                         $time, value, gnt, active_idx, blanking, e_val, e_gnt, e_src, e_blk);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1; req = '0; force_en = 1'b0; force_sel = '0;
        step(2);
        rst = 1'b0;
    endtask

    logic [N-1:0] g [22];
    logic         b [22];
    int           bad;

    initial begin
        for (int i = 0; i < N; i++) frames[i] = {4{8'(i)}};

        // 1: reset with every source requesting
        rst = 1'b1; req = 4'hF;
        for (int c = 0; c < 3; c++) begin
            step(1);
            chk_on = 1'b1;
            chk("rst_value", value, BLANKF);
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_blank", 32'(blanking), 32'h0);
        end
        rst = 1'b0; #1;
        chk("post_rst_value", value, BLANKF);
        step(1);
        chk("first_grant", 32'(gnt), 32'h1);
        chk("first_value", value, 32'h0000_0000);

        // 2: two requesters alternate with a gap
        reset_dut(); req = 4'b0101;
        for (int k = 1; k <= 21; k++) begin step(1); g[k] = gnt; b[k] = blanking; end
        chk("alt_k1", 32'(g[1]), 32'h1);   chk("alt_k8", 32'(g[8]), 32'h1);
        chk("alt_k9", 32'(g[9]), 32'h0);   chk("alt_k9_blank", 32'(b[9]), 32'h1);
        chk("alt_k10_blank", 32'(b[10]), 32'h1);
        chk("alt_k11", 32'(g[11]), 32'h4); chk("alt_k18", 32'(g[18]), 32'h4);
        chk("alt_k19", 32'(g[19]), 32'h0); chk("alt_k21", 32'(g[21]), 32'h1);

        // 3: lone requester never blanks
        reset_dut(); req = 4'b0010; bad = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (gnt !== 4'b0010 || value !== 32'h0101_0101 || blanking !== 1'b0) bad++;
        end
        chk("single_hold_bad_cycles", 32'(bad), 32'h0);

        // 4: early drop at dwell cycle 3
        reset_dut(); req = 4'b0011;
        step(4); req = 4'b0010;
        step(1); chk("drop_blank1", 32'(blanking), 32'h1); chk("drop_gnt0", 32'(gnt), 32'h0);
        step(1); chk("drop_blank2", 32'(blanking), 32'h1);
        step(1); chk("drop_regrant", 32'(gnt), 32'h2); chk("drop_value", value, 32'h0101_0101);

        // 5: force override, select change, release
        reset_dut(); req = 4'b0001;
        step(3); force_en = 1'b1; force_sel = 2'd3;
        step(1); chk("force3_value", value, 32'h0303_0303); chk("force3_gnt", 32'(gnt), 32'h8);
        force_sel = 2'd2;
        step(1); chk("force2_value", value, 32'h0202_0202); chk("force2_gnt", 32'(gnt), 32'h4);
        force_en = 1'b0;
        step(1); chk("release_blank1", 32'(blanking), 32'h1);
        step(1); chk("release_blank2", 32'(blanking), 32'h1);
        step(1); chk("release_regrant", 32'(gnt), 32'h1);

        // 6: reset during the gap restarts from pointer 0
        reset_dut(); req = 4'b0011;
        step(9); chk("gap_seen", 32'(blanking), 32'h1);
        rst = 1'b1;
        step(1); chk("midrst_gnt", 32'(gnt), 32'h0); chk("midrst_blank", 32'(blanking), 32'h0);
        chk("midrst_value", value, BLANKF);
        rst = 1'b0;
        step(1); chk("midrst_regrant", 32'(gnt), 32'h1);

        // Randomized traffic, live frame edits, force episodes and occasional resets
        for (int c = 0; c < 4000; c++) begin
            step(1);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) req = N'($urandom);
            if ($urandom_range(0, 39) == 0) force_en = ~force_en;
            if ($urandom_range(0, 9) == 0) force_sel = 2'($urandom);
            if ($urandom_range(0, 19) == 0) frames[$urandom_range(0, N-1)] = $urandom;
        end
        step(1);
        chk_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
